veririsc_core: RTL and testbench

VERIRISC_CORE -- requirements
Module: veririsc_core

---
 rtl/veririsc_pkg.sv | 35 +++
 rtl/veririsc_core_alu.sv | 29 ++
 rtl/veririsc_core.sv | 137 +++++++++++++
 tb/tb_veririsc_core.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/veririsc_pkg.sv
// Shared definitions for the VeriRISC accumulator core: opcodes, FSM states
// and helpers that pull the opcode and operand fields out of an instruction.
package veririsc_pkg;

  localparam int OPCODE_BITS = 3;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_MEM    = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  // Opcode lives in the top OPCODE_BITS bits of a data-width word.
  function automatic opcode_e f_opcode(input logic [63:0] i_word, input int i_dwidth);
    return opcode_e'(i_word[i_dwidth-1 -: OPCODE_BITS]);
  endfunction

  // Operand address lives in the low i_awidth bits; everything above is masked.
  function automatic logic [63:0] f_operand(input logic [63:0] i_word, input int i_awidth);
    return i_word & ~({64{1'b1}} << i_awidth);
  endfunction

endpackage

// File: rtl/veririsc_core_alu.sv
// Combinational accumulator ALU: computes the AC value written back at the
// end of a memory instruction, and flags a zero accumulator for SKZ.
module risc_alu
  import veririsc_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  opcode_e           i_opcode,
  input  logic [DWIDTH-1:0] i_ac,
  input  logic [DWIDTH-1:0] i_rdata,
  output logic [DWIDTH-1:0] o_result,
  output logic              o_ac_zero
);

  // Result select; STO and non-memory opcodes leave the accumulator as is.
  always_comb begin
    o_result = i_ac;
    case (i_opcode)
      OP_ADD:  o_result = i_ac + i_rdata;
      OP_AND:  o_result = i_ac & i_rdata;
      OP_XOR:  o_result = i_ac ^ i_rdata;
      OP_LDA:  o_result = i_rdata;
      default: o_result = i_ac;
    endcase
  end

  assign o_ac_zero = (i_ac == {DWIDTH{1'b0}});

endmodule

// File: rtl/veririsc_core.sv
// VeriRISC accumulator core: FETCH/EXEC/MEM/HALTED controller with PC, IR and
// AC, talking to a single ready-handshaked memory bus.
module veririsc_core
  import veririsc_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              resume,
  output logic              halt,
  output logic [AWIDTH-1:0] pc_out,
  output logic [DWIDTH-1:0] ac_out
);

  if (DWIDTH < AWIDTH + 3) begin : g_width_check
    $error("veririsc_core: DWIDTH must be at least AWIDTH+3");
  end

  localparam logic [AWIDTH-1:0] PC_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  state_e              r_state;
  state_e              w_state_next;
  logic [AWIDTH-1:0]   r_pc;
  logic [AWIDTH-1:0]   w_pc_next;
  logic [DWIDTH-1:0]   r_ac;
  logic [DWIDTH-1:0]   w_ac_next;
  logic [DWIDTH-1:0]   r_ir;
  logic [DWIDTH-1:0]   w_ir_next;
  opcode_e             w_opcode;
  logic [AWIDTH-1:0]   w_operand;
  logic [DWIDTH-1:0]   w_alu_result;
  logic                w_ac_zero;

  assign w_opcode  = f_opcode(64'(r_ir), DWIDTH);
  assign w_operand = AWIDTH'(f_operand(64'(r_ir), AWIDTH));

  risc_alu #(.DWIDTH(DWIDTH)) u_alu (
    .i_opcode  (w_opcode),
    .i_ac      (r_ac),
    .i_rdata   (mem_rdata),
    .o_result  (w_alu_result),
    .o_ac_zero (w_ac_zero)
  );

  // Bus and debug outputs decode directly from registered state only.
  assign mem_req   = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign mem_we    = (r_state == ST_MEM) && (w_opcode == OP_STO);
  assign mem_addr  = (r_state == ST_MEM) ? w_operand : r_pc;
  assign mem_wdata = r_ac;
  assign halt      = (r_state == ST_HALTED);
  assign pc_out    = r_pc;
  assign ac_out    = r_ac;

  // Next-state and datapath update; a bus cycle without ready changes nothing.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ac_next    = r_ac;
    w_ir_next    = r_ir;
    case (r_state)
      ST_FETCH: begin
        if (mem_ready) begin
          w_ir_next    = mem_rdata;
          w_pc_next    = r_pc + PC_ONE;
          w_state_next = ST_EXEC;
        end else begin
          w_state_next = ST_FETCH;
        end
      end
      ST_EXEC: begin
        case (w_opcode)
          OP_HLT: w_state_next = ST_HALTED;
          OP_SKZ: begin
            if (w_ac_zero) begin
              w_pc_next = r_pc + PC_ONE;
            end else begin
              w_pc_next = r_pc;
            end
            w_state_next = ST_FETCH;
          end
          OP_JMP: begin
            w_pc_next    = w_operand;
            w_state_next = ST_FETCH;
          end
          default: w_state_next = ST_MEM;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          w_ac_next    = w_alu_result;
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_MEM;
        end
      end
      ST_HALTED: begin
        if (resume) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_HALTED;
        end
      end
      default: w_state_next = ST_FETCH;
    endcase
  end

  // State register; reset always restarts with a fetch from address zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Architectural registers; reset wins over any in-flight bus transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= {AWIDTH{1'b0}};
      r_ac <= {DWIDTH{1'b0}};
      r_ir <= {DWIDTH{1'b0}};
    end else begin
      r_pc <= w_pc_next;
      r_ac <= w_ac_next;
      r_ir <= w_ir_next;
    end
  end

endmodule

// File: tb/tb_veririsc_core.sv
// Self-checking bench for veririsc_core (AWIDTH=5, DWIDTH=8): directed
// programs plus random terminating programs compared to an ISA-level model.
module tb_veririsc_core;

  logic       clk;
  logic       rst;
  logic       mem_req;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       mem_ready;
  logic       resume;
  logic       halt;
  logic [4:0] pc_out;
  logic [7:0] ac_out;

  logic [7:0] mem     [0:31];
  logic [7:0] ref_mem [0:31];
  logic       ready_val;
  logic       rand_wait;
  logic       rnd_bit;
  int         n_checks;
  int         n_fail;

  veririsc_core #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .resume    (resume),
    .halt      (halt),
    .pc_out    (pc_out),
    .ac_out    (ac_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on a completing write cycle.
  assign mem_rdata = mem[mem_addr];
  assign mem_ready = rand_wait ? rnd_bit : ready_val;
  always @(posedge clk) begin
    if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
  end
  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Wait-state stability: after a stalled cycle nothing visible may move.
  logic       p_wait;
  logic [4:0] p_addr;
  logic       p_we;
  logic [7:0] p_wdata;
  logic [4:0] p_pc;
  logic [7:0] p_ac;
  initial p_wait = 1'b0;
  always @(negedge clk) begin
    #1;
    if (p_wait) begin
      check("hold_req", {31'd0, mem_req}, 32'd1);
      check("hold_addr", {27'd0, mem_addr}, {27'd0, p_addr});
      check("hold_we", {31'd0, mem_we}, {31'd0, p_we});
      check("hold_wdata", {24'd0, mem_wdata}, {24'd0, p_wdata});
      check("hold_pc", {27'd0, pc_out}, {27'd0, p_pc});
      check("hold_ac", {24'd0, ac_out}, {24'd0, p_ac});
    end
    p_wait  = mem_req && !mem_ready && !rst;
    p_addr  = mem_addr;
    p_we    = mem_we;
    p_wdata = mem_wdata;
    p_pc    = pc_out;
    p_ac    = ac_out;
  end

  task automatic clear_mem();
    for (int k = 0; k < 32; k++) mem[k] = 8'h00;
  endtask

  task automatic apply_reset();
    rst = 1'b1; resume = 1'b0; ready_val = 1'b1; rand_wait = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", {27'd0, pc_out}, 32'd0);
    check("rst_ac", {24'd0, ac_out}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd1);
    check("rst_addr", {27'd0, mem_addr}, 32'd0);
    check("rst_halt", {31'd0, halt}, 32'd0);
    rst = 1'b0;
  endtask

  // Counts rising edges until halt is seen; expiry counts as a failure.
  task automatic run_to_halt(output int cycles);
    cycles = 0;
    while (cycles < 1000) begin
      @(negedge clk);
      cycles++;
      if (halt) break;
    end
    if (!halt) check("halt_timeout", {31'd0, halt}, 32'd1);
  endtask

  // Instruction-level reference: executes ref_mem, returns final PC/AC/cycles.
  task automatic model_run(output logic [4:0] pc, output logic [7:0] ac, output int cycles);
    logic [7:0] ir;
    logic [2:0] op;
    logic [4:0] a;
    pc = 5'd0; ac = 8'd0; cycles = 0;
    for (int n = 0; n < 100; n++) begin
      ir = ref_mem[pc];
      pc = pc + 5'd1;
      op = ir[7:5];
      a  = ir[4:0];
      if (op == 3'd0) begin
        cycles += 2;
        break;
      end else if (op == 3'd1) begin
        if (ac == 8'd0) pc = pc + 5'd1;
        cycles += 2;
      end else if (op == 3'd7) begin
        pc = a;
        cycles += 2;
      end else begin
        cycles += 3;
        case (op)
          3'd2:    ac = ac + ref_mem[a];
          3'd3:    ac = ac & ref_mem[a];
          3'd4:    ac = ac ^ ref_mem[a];
          3'd5:    ac = ref_mem[a];
          default: ref_mem[a] = ac;
        endcase
      end
    end
  endtask

  // Random program that always terminates: forward jumps only, data at 16..31.
  task automatic gen_program();
    logic [2:0] op;
    logic [4:0] a;
    clear_mem();
    for (int i = 0; i < 14; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7) a = 5'($urandom_range(i + 1, 14));
      else if (op >= 3'd2) a = 5'($urandom_range(16, 31));
      else a = 5'($urandom_range(0, 31));
      mem[i] = {op, a};
    end
    for (int k = 16; k < 32; k++) mem[k] = 8'($urandom);
  endtask

  task automatic random_run(input bit waits);
    logic [4:0] mpc;
    logic [7:0] mac;
    int         mcyc;
    int         cyc;
    int         diffs;
    gen_program();
    for (int k = 0; k < 32; k++) ref_mem[k] = mem[k];
    model_run(mpc, mac, mcyc);
    apply_reset();
    rand_wait = waits;
    run_to_halt(cyc);
    rand_wait = 1'b0;
    check("rand_pc", {27'd0, pc_out}, {27'd0, mpc});
    check("rand_ac", {24'd0, ac_out}, {24'd0, mac});
    if (!waits) check("rand_cycles", cyc, mcyc);
    diffs = 0;
    for (int k = 0; k < 32; k++) if (mem[k] !== ref_mem[k]) diffs++;
    check("rand_mem", diffs, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    n_checks = 0; n_fail = 0;
    rst = 1'b1; resume = 1'b0; ready_val = 1'b1; rand_wait = 1'b0;
    clear_mem();

    // LDA/ADD/STO/HLT with carry discarded
    mem[0] = 8'hBE; mem[1] = 8'h5F; mem[2] = 8'hDD; mem[3] = 8'h00;
    mem[30] = 8'h05; mem[31] = 8'hFE;
    apply_reset();
    run_to_halt(cyc);
    check("prog1_cycles", cyc, 32'd11);
    check("prog1_halt", {31'd0, halt}, 32'd1);
    check("prog1_pc", {27'd0, pc_out}, 32'd4);
    check("prog1_ac", {24'd0, ac_out}, 32'h03);
    check("prog1_mem29", {24'd0, mem[29]}, 32'h03);
    check("prog1_haltreq", {31'd0, mem_req}, 32'd0);

    // SKZ with AC==0 skips the JMP
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'hE5; mem[2] = 8'h00;
    apply_reset();
    run_to_halt(cyc);
    check("skz_cycles", cyc, 32'd4);
    check("skz_pc", {27'd0, pc_out}, 32'd3);

    // Three wait states on the first fetch, then resume tests
    clear_mem();
    mem[0] = 8'hBE; mem[1] = 8'h5F; mem[2] = 8'hDD; mem[3] = 8'h00;
    mem[30] = 8'h05; mem[31] = 8'hFE;
    apply_reset();
    ready_val = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("wait_addr", {27'd0, mem_addr}, 32'd0);
      check("wait_we", {31'd0, mem_we}, 32'd0);
      check("wait_pc", {27'd0, pc_out}, 32'd0);
    end
    ready_val = 1'b1;
    @(negedge clk);
    check("wait_done_pc", {27'd0, pc_out}, 32'd1);
    run_to_halt(cyc);
    check("wait_ac", {24'd0, ac_out}, 32'h03);
    check("wait_halt_pc", {27'd0, pc_out}, 32'd4);
    mem[4] = 8'hBE;
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_req", {31'd0, mem_req}, 32'd1);
    check("resume_addr", {27'd0, mem_addr}, 32'd4);
    check("resume_halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    run_to_halt(cyc);
    check("resume_run_pc", {27'd0, pc_out}, 32'd6);
    check("resume_run_ac", {24'd0, ac_out}, 32'h05);

    // Reset during a stalled STO must not write memory
    clear_mem();
    mem[0] = 8'hBE; mem[1] = 8'hDD; mem[29] = 8'hAA; mem[30] = 8'h05;
    apply_reset();
    repeat (5) @(negedge clk);
    ready_val = 1'b0;
    check("sto_we", {31'd0, mem_we}, 32'd1);
    check("sto_addr", {27'd0, mem_addr}, 32'd29);
    check("sto_wdata", {24'd0, mem_wdata}, 32'h05);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_pc", {27'd0, pc_out}, 32'd0);
    check("abort_ac", {24'd0, ac_out}, 32'd0);
    check("abort_req", {31'd0, mem_req}, 32'd1);
    check("abort_addr", {27'd0, mem_addr}, 32'd0);
    check("abort_mem29", {24'd0, mem[29]}, 32'hAA);
    rst = 1'b0;
    ready_val = 1'b1;

    // PC wrap 31 -> 0 followed by a taken skip
    clear_mem();
    mem[0] = 8'hFF; mem[31] = 8'h20;
    apply_reset();
    repeat (3) @(negedge clk);
    check("wrap_pc", {27'd0, pc_out}, 32'd0);
    @(negedge clk);
    check("wrap_skip_pc", {27'd0, pc_out}, 32'd1);
    check("wrap_skip_addr", {27'd0, mem_addr}, 32'd1);
    check("wrap_skip_req", {31'd0, mem_req}, 32'd1);
    run_to_halt(cyc);
    check("wrap_halt_pc", {27'd0, pc_out}, 32'd2);

    // Random programs, zero-wait then random wait states
    for (int r = 0; r < 12; r++) random_run(1'b0);
    for (int r = 0; r < 12; r++) random_run(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
